// File: rtl/gate_pkg.sv
// Shared encodings for the gate truth-table sequencer: gate function select and FSM states.
package gate_pkg;

   typedef enum logic [2:0] {
      MODE_OR   = 3'b000,
      MODE_AND  = 3'b001,
      MODE_XOR  = 3'b010,
      MODE_NOR  = 3'b011,
      MODE_NAND = 3'b100,
      MODE_XNOR = 3'b101
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A hold counter needs at least one bit even when each step lasts a single cycle.
   function automatic int unsigned hold_width(input int unsigned steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational N-input gate: applies the selected reduction operator to a vector.
module gate_reduce
   import gate_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0] vec_i,
   input  logic [2:0]       mode_i,
   output logic             y_o
);

   always_comb begin
      y_o = 1'b0;
      case (mode_i)
         MODE_OR:   y_o = |vec_i;
         MODE_AND:  y_o = &vec_i;
         MODE_XOR:  y_o = ^vec_i;
         MODE_NOR:  y_o = ~|vec_i;
         MODE_NAND: y_o = ~&vec_i;
         MODE_XNOR: y_o = ~^vec_i;
         default:   y_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_truth_table.sv
// Self-sequencing gate evaluator: sweeps every input combination, holds each for
// STEP_CYCLES cycles and records the gate's truth table (truth_table, since "table" is reserved).
module gate_truth_table
   import gate_pkg::*;
#(
   parameter int unsigned INPUT_SIZE  = 2,
   parameter int unsigned STEP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [2:0]                 mode,
   output logic                       busy,
   output logic                       done,
   output logic [INPUT_SIZE-1:0]      inputs,
   output logic                       gate_out,
   output logic [2**INPUT_SIZE-1:0]   truth_table
);

   localparam int unsigned TW = 2**INPUT_SIZE;
   localparam int unsigned HW = hold_width(STEP_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_CYCLES - 1);

   state_e                state_q;
   logic [2:0]            mode_q;
   logic [INPUT_SIZE-1:0] idx_q;
   logic [HW-1:0]         hold_q;
   logic [TW-1:0]         table_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  cap_bit;
   logic                  last_hold;

   assign last_hold = (hold_q == HOLD_LAST);

   // idx stays at all-ones through DONE and is only cleared on the way back to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_OR;
         idx_q   <= '0;
         hold_q  <= '0;
         table_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  mode_q  <= mode;
                  table_q <= '0;
                  idx_q   <= '0;
                  hold_q  <= '0;
               end
            end
            RUN: begin
               if (last_hold) begin
                  table_q[idx_q] <= cap_bit;
                  hold_q         <= '0;
                  if (idx_q == '1) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               idx_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   gate_reduce #(.WIDTH(INPUT_SIZE)) u_out_gate (
      .vec_i  (idx_q),
      .mode_i (mode_q),
      .y_o    (gate_out)
   );

   gate_reduce #(.WIDTH(INPUT_SIZE)) u_cap_gate (
      .vec_i  (idx_q),
      .mode_i (mode_q),
      .y_o    (cap_bit)
   );

   assign inputs      = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign truth_table = table_q;

endmodule

// File: tb/tb_gate_truth_table.sv
// Randomized bench for gate_truth_table across several INPUT_SIZE/STEP_CYCLES configurations.
module tb_gate_truth_table;

   localparam int NCFG = 4;
   localparam int CFG_N [NCFG] = '{2, 3, 1, 8};
   localparam int CFG_S [NCFG] = '{1, 3, 1, 1};
   localparam int CFG_A [NCFG] = '{0, 2, 4, 1};
   localparam int CFG_B [NCFG] = '{1, 3, 5, 0};
   localparam int CFG_C [NCFG] = '{2, 2, 1, 2};
   localparam int CFG_R [NCFG] = '{6, 3, 6, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fin    = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic mark_finished();
      n_fin++;
   endtask

   // Gate value from the number of ones among the n input bits.
   function automatic logic ref_f(input int unsigned i, input int unsigned n, input logic [2:0] m);
      int unsigned ones = $countones(i);
      case (m)
         3'd0:    return ones > 0;
         3'd1:    return ones == n;
         3'd2:    return ones % 2 == 1;
         3'd3:    return ones == 0;
         3'd4:    return ones != n;
         3'd5:    return ones % 2 == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [255:0] ref_table(input logic [2:0] m, input int unsigned n);
      logic [255:0] t = '0;
      for (int unsigned i = 0; i < (1 << n); i++) t[i] = ref_f(i, n, m);
      return t;
   endfunction

   function automatic logic [255:0] low_mask(input int unsigned p);
      logic [255:0] k = '0;
      for (int unsigned i = 0; i < p; i++) k[i] = 1'b1;
      return k;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int N  = CFG_N[g];
      localparam int S  = CFG_S[g];
      localparam int TW = 2**N;

      logic             rst;
      logic             start;
      logic [2:0]       mode;
      logic             busy;
      logic             done;
      logic [N-1:0]     inputs;
      logic             gate_out;
      logic [TW-1:0]    tbl;
      string            pfx;

      gate_truth_table #(.INPUT_SIZE(N), .STEP_CYCLES(S)) dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start),
         .mode        (mode),
         .busy        (busy),
         .done        (done),
         .inputs      (inputs),
         .gate_out    (gate_out),
         .truth_table (tbl)
      );

      // Called on a negedge while the DUT is idle; returns on the negedge of the idle cycle after done.
      task automatic sweep(input logic [2:0] m, input bit hold);
         logic [255:0] full;
         int unsigned nc;
         full  = ref_table(m, N);
         nc    = TW * S;
         start = 1'b1;
         mode  = m;
         @(negedge clk);
         for (int unsigned c = 0; c < nc; c++) begin
            check({pfx, "busy"},     busy,     1);
            check({pfx, "done_low"}, done,     0);
            check({pfx, "inputs"},   inputs,   c / S);
            check({pfx, "gate_out"}, gate_out, ref_f(c / S, N, m));
            check({pfx, "table_partial"}, tbl, full & low_mask(c / S));
            start = hold;
            mode  = 3'($urandom);
            @(negedge clk);
         end
         check({pfx, "done_pulse"},  done,   1);
         check({pfx, "busy_done"},   busy,   0);
         check({pfx, "inputs_done"}, inputs, TW - 1);
         check({pfx, "table_final"}, tbl,    full);
         if (!hold) start = 1'b0;
         mode = 3'($urandom);
         @(negedge clk);
         check({pfx, "idle_busy"},   busy,     0);
         check({pfx, "idle_done"},   done,     0);
         check({pfx, "idle_inputs"}, inputs,   0);
         check({pfx, "idle_table"},  tbl,      full);
         check({pfx, "idle_gate"},   gate_out, ref_f(0, N, m));
      endtask

      task automatic mid_reset();
         int unsigned ri;
         ri    = (TW > 2) ? 2 : 1;
         start = 1'b1;
         mode  = 3'd4;
         @(negedge clk);
         start = 1'b0;
         repeat (ri * S) @(negedge clk);
         check({pfx, "pre_reset_inputs"}, inputs, ri);
         #2 rst = 1'b1;
         #1;
         check({pfx, "arst_busy"},   busy,     0);
         check({pfx, "arst_done"},   done,     0);
         check({pfx, "arst_inputs"}, inputs,   0);
         check({pfx, "arst_table"},  tbl,      0);
         check({pfx, "arst_gate"},   gate_out, 0);
         @(negedge clk);
         rst = 1'b0;
         for (int unsigned c = 0; c < TW * S + 2; c++) begin
            @(negedge clk);
            check({pfx, "post_reset_busy"}, busy, 0);
            check({pfx, "post_reset_done"}, done, 0);
         end
      endtask

      initial begin
         pfx   = $sformatf("cfg%0d.", g);
         rst   = 1'b1;
         start = 1'b0;
         mode  = 3'd0;
         repeat (2) @(negedge clk);
         check({pfx, "rst_busy"},   busy,     0);
         check({pfx, "rst_done"},   done,     0);
         check({pfx, "rst_inputs"}, inputs,   0);
         check({pfx, "rst_table"},  tbl,      0);
         check({pfx, "rst_gate"},   gate_out, 0);
         rst = 1'b0;
         @(negedge clk);
         sweep(3'(CFG_A[g]), 1'b0);
         sweep(3'(CFG_B[g]), 1'b1);
         sweep(3'(CFG_C[g]), 1'b0);
         mid_reset();
         sweep(3'd6, 1'b0);
         for (int r = 0; r < CFG_R[g]; r++)
            sweep(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         start = 1'b0;
         mark_finished();
      end
   end

   initial begin
      for (int t = 0; t < 20000 && n_fin < NCFG; t++) @(posedge clk);
      check("all_configs_finished", n_fin, NCFG);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
